// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch PC sequencer with stall/flush control.
//
// Drives pc_o / imem_ce_o / imem_req_o toward instruction memory through a
// req/ack handshake, arbitrates exception flush and branch redirects, and
// emits a 6-bit stall vector to the pipeline registers.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   stallreq_id_i/ex_i ID / EX stage stall requests
//   branch_flag_i      branch taken, target on branch_target_i
//   flush_i            exception flush, handler address on new_pc_i
//   imem_ack_i         instruction memory returned data for pc_o
//   imem_ce_o          instruction memory chip enable
//   imem_req_o         fetch request, held while waiting for ack
//   pc_o               current fetch address (word aligned)
//   stall_o            [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB
//   flush_o            pipeline register flush, one-cycle pulse
//   fetch_err_o        sticky fetch timeout
//   perf_stall_o       cycles with stall_o[0]=1 (saturating)
//
// Build option: define FETCH_CTRL_PERF_EN to build the stall cycle counter;
// otherwise perf_stall_o is tied to zero.
module fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              imem_ack_i,
  output logic              imem_ce_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic              fetch_err_o,
  output logic [31:0]       perf_stall_o
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_RST, S_REQ, S_ERR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_next;
  logic              ce_next, req_next, err_next;
  logic              pend, pend_next;
  logic [ADDR_W-1:0] pend_tgt, pend_tgt_next;
  logic [CNT_W-1:0]  wcnt, wcnt_next;

  logic [ADDR_W-1:0] br_tgt, flush_tgt;
  logic              pipe_stall;

  assign br_tgt     = branch_target_i & ~ADDR_W'(3);
  assign flush_tgt  = new_pc_i & ~ADDR_W'(3);
  assign pipe_stall = stallreq_ex_i | stallreq_id_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RST;
      pc_o        <= '0;
      imem_ce_o   <= 1'b0;
      imem_req_o  <= 1'b0;
      fetch_err_o <= 1'b0;
      flush_o     <= 1'b0;
      pend        <= 1'b0;
      pend_tgt    <= '0;
      wcnt        <= '0;
    end else begin
      state       <= state_next;
      pc_o        <= pc_next;
      imem_ce_o   <= ce_next;
      imem_req_o  <= req_next;
      fetch_err_o <= err_next;
      flush_o     <= flush_i;
      pend        <= pend_next;
      pend_tgt    <= pend_tgt_next;
      wcnt        <= wcnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc_o;
    ce_next       = imem_ce_o;
    req_next      = imem_req_o;
    err_next      = fetch_err_o;
    pend_next     = pend;
    pend_tgt_next = pend_tgt;
    wcnt_next     = wcnt;

    if (flush_i) begin
      state_next = S_REQ;
      pc_next    = flush_tgt;
      ce_next    = 1'b1;
      req_next   = 1'b1;
      err_next   = 1'b0;
      pend_next  = 1'b0;
      wcnt_next  = '0;
    end else begin
      unique case (state)
        S_RST: begin
          state_next = S_REQ;
          pc_next    = RESET_PC;
          ce_next    = 1'b1;
          req_next   = 1'b1;
        end
        S_REQ: begin
          if (imem_ack_i) begin
            wcnt_next = '0;
            if (pipe_stall) begin
              // A branch seen while the pipe is stalled must not be lost.
              if (branch_flag_i) begin
                pend_next     = 1'b1;
                pend_tgt_next = br_tgt;
              end
            end else if (branch_flag_i) begin
              // A fresh branch is newer than any pending one.
              pc_next   = br_tgt;
              pend_next = 1'b0;
            end else if (pend) begin
              pc_next   = pend_tgt;
              pend_next = 1'b0;
            end else begin
              pc_next = pc_o + ADDR_W'(4);
            end
          end else begin
            wcnt_next = wcnt + 1'b1;
            if (branch_flag_i) begin
              pend_next     = 1'b1;
              pend_tgt_next = br_tgt;
            end
            if (wcnt == CNT_W'(MAX_WAIT - 1)) begin
              state_next = S_ERR;
              err_next   = 1'b1;
              req_next   = 1'b0;
            end
          end
        end
        S_ERR: ;
        default: state_next = S_RST;
      endcase
    end
  end

  always_comb begin
    stall_o = 6'b000000;
    if (flush_i)                       stall_o = 6'b000000;
    else if (state == S_ERR)           stall_o = 6'b111111;
    else if (stallreq_ex_i)            stall_o = 6'b001111;
    else if (stallreq_id_i)            stall_o = 6'b000111;
    else if (state == S_REQ && !imem_ack_i) stall_o = 6'b000011;
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt <= '0;
    end else if (stall_o[0] && perf_cnt != '1) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign perf_stall_o = perf_cnt;
`else
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int unsigned MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id_i, stallreq_ex_i, branch_flag_i, flush_i, imem_ack_i;
  logic [31:0] branch_target_i, new_pc_i;
  logic        imem_ce_o, imem_req_o, flush_o, fetch_err_o;
  logic [31:0] pc_o, perf_stall_o;
  logic [5:0]  stall_o;

  int total = 0;
  int bad   = 0;

  fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .flush_i(flush_i), .new_pc_i(new_pc_i), .imem_ack_i(imem_ack_i),
    .imem_ce_o(imem_ce_o), .imem_req_o(imem_req_o), .pc_o(pc_o),
    .stall_o(stall_o), .flush_o(flush_o), .fetch_err_o(fetch_err_o),
    .perf_stall_o(perf_stall_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = waiting for first fetch, 1 = fetching, 2 = timed out.
  int          m_phase;
  logic [31:0] m_pc, m_tgt, m_perf;
  logic        m_ce, m_req, m_fl, m_err, m_pend;
  int          m_wait;

  function automatic logic [5:0] exp_stall();
    if (flush_i)                         return 6'h00;
    if (m_phase == 2)                    return 6'h3F;
    if (stallreq_ex_i)                   return 6'h0F;
    if (stallreq_id_i)                   return 6'h07;
    if (m_phase == 1 && !imem_ack_i)     return 6'h03;
    return 6'h00;
  endfunction

  function automatic logic [31:0] exp_perf();
`ifdef FETCH_CTRL_PERF_EN
    return m_perf;
`else
    return 32'h0;
`endif
  endfunction

  task automatic set_in(input logic r, input logic ack, input logic fl, input logic ex,
                        input logic id, input logic br, input logic [31:0] tgt,
                        input logic [31:0] npc);
    rst = r; imem_ack_i = ack; flush_i = fl; stallreq_ex_i = ex;
    stallreq_id_i = id; branch_flag_i = br; branch_target_i = tgt; new_pc_i = npc;
    #1;
  endtask

  task automatic tick();
    logic [5:0] s;
    s = exp_stall();
    if (rst) begin
      m_phase = 0; m_pc = '0; m_ce = 0; m_req = 0; m_fl = 0; m_err = 0;
      m_pend = 0; m_tgt = '0; m_wait = 0; m_perf = '0;
    end else begin
      if (s[0] && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
      m_fl = flush_i;
      if (flush_i) begin
        m_phase = 1; m_pc = new_pc_i & ~32'h3; m_ce = 1; m_req = 1;
        m_err = 0; m_pend = 0; m_wait = 0;
      end else if (m_phase == 0) begin
        m_phase = 1; m_pc = 32'h0; m_ce = 1; m_req = 1;
      end else if (m_phase == 1) begin
        if (imem_ack_i) begin
          m_wait = 0;
          if (stallreq_ex_i || stallreq_id_i) begin
            if (branch_flag_i) begin m_pend = 1; m_tgt = branch_target_i & ~32'h3; end
          end else if (branch_flag_i) begin
            m_pc = branch_target_i & ~32'h3; m_pend = 0;
          end else if (m_pend) begin
            m_pc = m_tgt; m_pend = 0;
          end else begin
            m_pc = m_pc + 32'd4;
          end
        end else begin
          m_wait++;
          if (branch_flag_i) begin m_pend = 1; m_tgt = branch_target_i & ~32'h3; end
          if (m_wait == MAX_WAIT) begin m_phase = 2; m_err = 1; m_req = 0; end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    total++; if (pc_o !== 32'h0 || imem_ce_o !== 1'b0 || imem_req_o !== 1'b0) begin
      bad++; $display("FAIL reset_regs pc=%h ce=%b req=%b required pc=0 ce=0 req=0", pc_o, imem_ce_o, imem_req_o);
    end
    total++; if (stall_o !== 6'h00 || flush_o !== 1'b0 || fetch_err_o !== 1'b0 || perf_stall_o !== 32'h0) begin
      bad++; $display("FAIL reset_misc stall=%h flush=%b err=%b perf=%0d required 0", stall_o, flush_o, fetch_err_o, perf_stall_o);
    end
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    total++; if (imem_ce_o !== 1'b0) begin bad++; $display("FAIL first_cycle_ce got %b required 0", imem_ce_o); end
    tick();
    total++; if (imem_ce_o !== 1'b1 || imem_req_o !== 1'b1 || pc_o !== 32'h0) begin
      bad++; $display("FAIL first_fetch ce=%b req=%b pc=%h required 1 1 0", imem_ce_o, imem_req_o, pc_o);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (pc_o !== 32'(4 * i)) begin bad++; $display("FAIL seq_pc got %h required %h", pc_o, 32'(4 * i)); end
    end
  endtask

  task automatic test_ack_wait();
    logic [31:0] p;
    p = pc_o;
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (stall_o !== 6'b000011) begin bad++; $display("FAIL wait_stall got %b required 000011", stall_o); end
      tick();
      total++; if (pc_o !== p) begin bad++; $display("FAIL wait_hold got %h required %h", pc_o, p); end
    end
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    total++; if (pc_o !== p + 32'd4) begin bad++; $display("FAIL wait_resume got %h required %h", pc_o, p + 32'd4); end
  endtask

  task automatic test_branch_wait();
    logic [31:0] p;
    p = pc_o;
    set_in(0, 0, 0, 0, 0, 1, 32'h0000_0200, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 1, 32'h0000_0103, 0);
    tick();
    total++; if (pc_o !== p) begin bad++; $display("FAIL branch_hold got %h required %h", pc_o, p); end
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    total++; if (pc_o !== 32'h100) begin bad++; $display("FAIL branch_redirect got %h required 00000100", pc_o); end
    tick();
    total++; if (pc_o !== 32'h104) begin bad++; $display("FAIL branch_after got %h required 00000104", pc_o); end
  endtask

  task automatic test_flush();
    set_in(0, 0, 1, 1, 0, 1, 32'h300, 32'h20);
    total++; if (stall_o !== 6'h00) begin bad++; $display("FAIL flush_stall got %b required 000000", stall_o); end
    tick();
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    total++; if (pc_o !== 32'h20 || flush_o !== 1'b1) begin
      bad++; $display("FAIL flush_take pc=%h flush=%b required 00000020 1", pc_o, flush_o);
    end
    tick();
    total++; if (pc_o !== 32'h24 || flush_o !== 1'b0) begin
      bad++; $display("FAIL flush_pulse pc=%h flush=%b required 00000024 0", pc_o, flush_o);
    end
  endtask

  task automatic test_timeout();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (MAX_WAIT - 1) tick();
    total++; if (fetch_err_o !== 1'b0) begin bad++; $display("FAIL timeout_early err=%b required 0", fetch_err_o); end
    tick();
    total++; if (fetch_err_o !== 1'b1 || imem_req_o !== 1'b0 || stall_o !== 6'h3F) begin
      bad++; $display("FAIL timeout err=%b req=%b stall=%h required 1 0 3f", fetch_err_o, imem_req_o, stall_o);
    end
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    total++; if (fetch_err_o !== 1'b1) begin bad++; $display("FAIL err_sticky err=%b required 1", fetch_err_o); end
    set_in(0, 0, 1, 0, 0, 0, 0, 32'h40);
    tick();
    total++; if (fetch_err_o !== 1'b0 || pc_o !== 32'h40 || imem_req_o !== 1'b1) begin
      bad++; $display("FAIL err_flush err=%b pc=%h req=%b required 0 00000040 1", fetch_err_o, pc_o, imem_req_o);
    end
  endtask

  task automatic test_wrap_perf();
    set_in(0, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFFF);
    tick();
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    total++; if (pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL align got %h required fffffffc", pc_o); end
    tick();
    total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL wrap got %h required 00000000", pc_o); end
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 1, 0, 1, 0, 0, 0, 0);
    repeat (4) tick();
`ifdef FETCH_CTRL_PERF_EN
    total++; if (perf_stall_o !== 32'd4) begin bad++; $display("FAIL perf got %0d required 4", perf_stall_o); end
`else
    total++; if (perf_stall_o !== 32'd0) begin bad++; $display("FAIL perf got %0d required 0", perf_stall_o); end
`endif
  endtask

  task automatic test_random();
    int drought;
    logic ack;
    drought = 0;
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 2000; c++) begin
      if (drought == 0 && $urandom_range(0, 99) < 2) drought = MAX_WAIT + 2;
      if (drought > 0) begin ack = 0; drought--; end
      else ack = ($urandom_range(0, 99) < 70);
      set_in($urandom_range(0, 199) == 0, ack, $urandom_range(0, 99) < 4,
             $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 15, $urandom(), $urandom());
      total++; if (stall_o !== exp_stall()) begin
        bad++; $display("FAIL rnd_stall cycle %0d got %b required %b", c, stall_o, exp_stall());
      end
      total++; if (pc_o !== m_pc || imem_ce_o !== m_ce || imem_req_o !== m_req) begin
        bad++; $display("FAIL rnd_fetch cycle %0d pc=%h ce=%b req=%b required %h %b %b",
                        c, pc_o, imem_ce_o, imem_req_o, m_pc, m_ce, m_req);
      end
      total++; if (flush_o !== m_fl || fetch_err_o !== m_err || perf_stall_o !== exp_perf()) begin
        bad++; $display("FAIL rnd_status cycle %0d flush=%b err=%b perf=%0d required %b %b %0d",
                        c, flush_o, fetch_err_o, perf_stall_o, m_fl, m_err, exp_perf());
      end
      tick();
    end
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_ack_wait();
    test_branch_wait();
    test_flush();
    test_timeout();
    test_wrap_perf();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
